// File: rtl/traffic_light_controller.sv
// Fixed-time six-state lamp sequencer for a T-junction.
// Lamps decode straight from the state register; each state dwells a set number of cycles.
module traffic_light_controller #(
    parameter int TMG   = 7,
    parameter int TY    = 2,
    parameter int TTG   = 5,
    parameter int TSG   = 3,
    parameter int CNT_W = 8
) (
    input  logic       clk,
    input  logic       rst,
    output logic [2:0] light_M1,
    output logic [2:0] light_S,
    output logic [2:0] light_MT,
    output logic [2:0] light_M2
);

    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] GREEN  = 3'b001;

    localparam logic [CNT_W-1:0] LAST_MG = CNT_W'(TMG - 1);
    localparam logic [CNT_W-1:0] LAST_Y  = CNT_W'(TY - 1);
    localparam logic [CNT_W-1:0] LAST_TG = CNT_W'(TTG - 1);
    localparam logic [CNT_W-1:0] LAST_SG = CNT_W'(TSG - 1);

    typedef enum logic [2:0] {
        S1 = 3'd0,
        S2 = 3'd1,
        S3 = 3'd2,
        S4 = 3'd3,
        S5 = 3'd4,
        S6 = 3'd5
    } state_e;

    // Held as a raw code so unencoded values (6, 7) remain representable.
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] last;
    logic [2:0]       succ;
    logic             legal;

    // Dwell limit and successor for the current state.
    always_comb begin
        last  = LAST_MG;
        succ  = S1;
        legal = 1'b1;
        case (state_q)
            S1: begin last = LAST_MG; succ = S2; end
            S2: begin last = LAST_Y;  succ = S3; end
            S3: begin last = LAST_TG; succ = S4; end
            S4: begin last = LAST_Y;  succ = S5; end
            S5: begin last = LAST_SG; succ = S6; end
            S6: begin last = LAST_Y;  succ = S1; end
            default: legal = 1'b0;
        endcase
    end

    // Advance on the final dwell cycle, else count; bad codes fall back to S1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        if (!legal) begin
            state_d = S1;
            cnt_d   = '0;
        end else if (cnt_q == last) begin
            state_d = succ;
            cnt_d   = '0;
        end
    end

    // State and dwell registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Moore lamp decode; anything unencoded shows all red.
    always_comb begin
        light_M1 = RED;
        light_M2 = RED;
        light_MT = RED;
        light_S  = RED;
        case (state_q)
            S1: begin light_M1 = GREEN;  light_M2 = GREEN;  end
            S2: begin light_M1 = GREEN;  light_M2 = YELLOW; end
            S3: begin light_M1 = GREEN;  light_MT = GREEN;  end
            S4: begin light_M1 = YELLOW; light_MT = YELLOW; end
            S5: light_S = GREEN;
            S6: light_S = YELLOW;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_traffic_light_controller.sv
// Directed bench for traffic_light_controller.
// Default and all-ones timing instances share clock and reset.
module tb_traffic_light_controller;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] m1, s, mt, m2;
    logic [2:0] fm1, fs, fmt, fm2;
    int         n_chk  = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    traffic_light_controller dut (
        .clk      (clk),
        .rst      (rst),
        .light_M1 (m1),
        .light_S  (s),
        .light_MT (mt),
        .light_M2 (m2)
    );

    traffic_light_controller #(
        .TMG (1),
        .TY  (1),
        .TTG (1),
        .TSG (1)
    ) fast (
        .clk      (clk),
        .rst      (rst),
        .light_M1 (fm1),
        .light_S  (fs),
        .light_MT (fmt),
        .light_M2 (fm2)
    );

    // Lamp bundle {M1, M2, MT, S} per state index, 6 = all red.
    function automatic logic [11:0] lamps(int st);
        case (st)
            0:       return {G, G, R, R};
            1:       return {G, Y, R, R};
            2:       return {G, R, G, R};
            3:       return {Y, R, Y, R};
            4:       return {R, R, R, G};
            5:       return {R, R, R, Y};
            default: return {R, R, R, R};
        endcase
    endfunction

    // State index k edges after reset release, default timing.
    function automatic int st_at(int k);
        int p;
        p = k % 21;
        if (p < 7)  return 0;
        if (p < 9)  return 1;
        if (p < 14) return 2;
        if (p < 16) return 3;
        if (p < 19) return 4;
        return 5;
    endfunction

    task automatic check(string tag, logic [11:0] obs, logic [11:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_safe(string tag, logic [11:0] l);
        logic [2:0] a, b, c, d;
        logic ok;
        {a, b, c, d} = l;
        ok = $onehot(a) && $onehot(b) && $onehot(c) && $onehot(d);
        if (c != R && b != R) ok = 1'b0;
        if (d != R && (a != R || b != R || c != R)) ok = 1'b0;
        n_chk++;
        assert (ok === 1'b1) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=safe one-hot", tag, l);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held for two edges.
        rst = 1'b0;
        step();
        step();
        check("reset", {m1, m2, mt, s}, lamps(0));
        check("reset_fast", {fm1, fm2, fmt, fs}, lamps(0));
        rst = 1'b1;

        // Three full default periods, every edge checked.
        for (int k = 1; k <= 63; k++) begin
            step();
            check($sformatf("seq_e%0d", k), {m1, m2, mt, s}, lamps(st_at(k)));
            check_safe($sformatf("safe_e%0d", k), {m1, m2, mt, s});
        end

        // Reset mid-S3 and timing after release.
        rst = 1'b0;
        step();
        rst = 1'b1;
        for (int k = 1; k <= 11; k++) step();
        check("pre_abort_s3", {m1, m2, mt, s}, lamps(2));
        rst = 1'b0;
        step();
        check("abort_s1", {m1, m2, mt, s}, lamps(0));
        rst = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step();
            check($sformatf("rerun_e%0d", k), {m1, m2, mt, s},
                  lamps(k < 7 ? 0 : 1));
        end

        // Illegal state code decodes all red, then recovers to S1.
        force dut.state_q = 3'b111;
        #1;
        check("illegal_red", {m1, m2, mt, s}, lamps(6));
        release dut.state_q;
        step();
        check("illegal_recover", {m1, m2, mt, s}, lamps(0));

        // Unit dwell instance: one state per edge, period 6.
        rst = 1'b0;
        step();
        check("fast_reset", {fm1, fm2, fmt, fs}, lamps(0));
        rst = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            step();
            check($sformatf("fast_e%0d", k), {fm1, fm2, fmt, fs}, lamps(k % 6));
            check_safe($sformatf("fast_safe_e%0d", k), {fm1, fm2, fmt, fs});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
